fp_mul_add_unit: RTL and testbench

Multi-cycle, parametrised floating-point multiply/add unit with valid/ready handshakes on request and response. It executes FADD/FSUB/FMUL/FMADD/FMSUB/FNMADD/FNMSUB for any IEEE-754-style format and sits between the FP issue stage and FP writeback. Compared with the combinational unit, it adds:
- a bias derived from EXPONENT_WIDTH;
- canonical quiet NaN on every invalid result;
- rounding-mode-correct overflow results;
- flush-to-zero of tiny results;
- accumulation of flags across the multiply and add steps;
- a kill input for pipeline flush.

---
 rtl/fp_mul_add_unit.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_add_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fp_mul_add_unit.sv
// fp_mul_add_unit: multi-cycle IEEE-754-style FADD/FSUB/FMUL/FMADD/FMSUB/FNMADD/FNMSUB unit with valid/ready handshakes
// Ports: clk, rst (async, active-high); i_kill aborts the in-flight operation;
//   request  i_req_valid/o_req_ready, i_command, i_rounding_mode, i_fp_src1..3 (latched at accept);
//   response o_resp_valid/i_resp_ready, o_fp_result, o_flags {NV,DZ,OF,UF,NX}.
// Commands: FADD=0 FSUB=1 FMUL=2 FMADD=3 FMSUB=4 FNMADD=5 FNMSUB=6. Rounding: RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4.
module fp_mul_add_unit #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_kill,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_command,
  input  logic [2:0]       i_rounding_mode,
  input  logic [WIDTH-1:0] i_fp_src1,
  input  logic [WIDTH-1:0] i_fp_src2,
  input  logic [WIDTH-1:0] i_fp_src3,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [WIDTH-1:0] o_fp_result,
  output logic [4:0]       o_flags
);
  localparam int E = EXPONENT_WIDTH;
  localparam int F = FRACTION_WIDTH;
  localparam int W = WIDTH;
  localparam int BIAS = 2 ** (E - 1) - 1;
  localparam logic signed [E+1:0] EMAX = (E + 2)'(2 ** E - 2);
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
  localparam logic [2:0] FADD = 3'd0, FSUB = 3'd1, FMUL = 3'd2, FMADD = 3'd3, FMSUB = 3'd4, FNMADD = 3'd5, FNMSUB = 3'd6;
  localparam logic [2:0] RNE = 3'd0, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [4:0] FL_NV = 5'b10000, FL_OF = 5'b00100, FL_UF = 5'b00010, FL_NX = 5'b00001;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cmd, r_rm;
  logic [W-1:0] r_s1, r_s2, r_s3, r_prod, r_result;
  logic [4:0] r_flags;
  logic w_fused;
  logic [W-1:0] w_a, w_b;
  logic [W+4:0] w_mul, w_add;
  function automatic logic is_nan(input logic [W-1:0] x);
    return &x[W-2:F] && |x[F-1:0];
  endfunction
  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[F-1];
  endfunction
  function automatic logic is_inf(input logic [W-1:0] x);
    return &x[W-2:F] && ~|x[F-1:0];
  endfunction
  function automatic logic is_zero(input logic [W-1:0] x);
    return ~|x[W-2:F];
  endfunction
  function automatic int lzc(input logic [F+3:0] v);
    int n;
    n = F + 4;
    for (int i = 0; i < F + 4; i++) if (v[i]) n = F + 3 - i;
    return n;
  endfunction
  // m = {hidden, fraction, guard, round, sticky}; returns {flags, packed result}
  function automatic logic [W+4:0] round_pack(input logic s, input logic signed [E+1:0] e, input logic [F+3:0] m, input logic [2:0] rm);
    logic nx, inc;
    logic [F+1:0] r;
    logic signed [E+1:0] er;
    nx = |m[2:0];
    inc = rm == RNE ? m[2] & (m[3] | m[1] | m[0]) :
          rm == RDN ? s & nx :
          rm == RUP ? !s & nx :
          rm == RMM ? m[2] : 1'b0;
    r = {1'b0, m[F+3:3]} + {{(F+1){1'b0}}, inc};
    er = e + {{(E+1){1'b0}}, r[F+1]};
    if (er > EMAX)
      return {FL_OF | FL_NX, (rm == RNE || rm == RMM || (rm == RUP && !s) || (rm == RDN && s)) ?
              {s, {E{1'b1}}, {F{1'b0}}} : {s, {(E-1){1'b1}}, 1'b0, {F{1'b1}}}};
    if (er[E+1] || er == '0) return {FL_UF | FL_NX, s, {(W-1){1'b0}}};
    return {4'b0, nx, s, er[E-1:0], r[F+1] ? r[F:1] : r[F-1:0]};
  endfunction
  function automatic logic [W+4:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] rm);
    logic s;
    logic [2*F+1:0] p, pn;
    logic signed [E+1:0] e;
    s = a[W-1] ^ b[W-1];
    p = {{(F+1){1'b0}}, 1'b1, a[F-1:0]} * {{(F+1){1'b0}}, 1'b1, b[F-1:0]};
    pn = p[2*F+1] ? p : p << 1;
    e = {2'b0, a[W-2:F]} + {2'b0, b[W-2:F]} - (E + 2)'(BIAS) + {{(E+1){1'b0}}, p[2*F+1]};
    if (is_nan(a) || is_nan(b)) return {is_snan(a) || is_snan(b) ? FL_NV : 5'b0, QNAN};
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return {FL_NV, QNAN};
    if (is_inf(a) || is_inf(b)) return {5'b0, s, {E{1'b1}}, {F{1'b0}}};
    if (is_zero(a) || is_zero(b)) return {5'b0, s, {(W-1){1'b0}}};
    return round_pack(s, e, {pn[2*F+1:F-1], |pn[F-2:0]}, rm);
  endfunction
  function automatic logic [W+4:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] rm);
    logic [W-1:0] l, t;
    logic [F+3:0] ml, ms, msa, d4;
    logic [F+4:0] sum;
    logic [E-1:0] de;
    logic signed [E+1:0] e;
    int sh, n;
    if (is_nan(a) || is_nan(b)) return {is_snan(a) || is_snan(b) ? FL_NV : 5'b0, QNAN};
    if (is_inf(a) && is_inf(b) && a[W-1] != b[W-1]) return {FL_NV, QNAN};
    if (is_inf(a)) return {5'b0, a};
    if (is_inf(b)) return {5'b0, b};
    if (is_zero(a) && is_zero(b)) return {5'b0, (a[W-1] && b[W-1]) || rm == RDN, {(W-1){1'b0}}};
    if (is_zero(a)) return {5'b0, b};
    if (is_zero(b)) return {5'b0, a};
    l = a[W-2:0] >= b[W-2:0] ? a : b;
    t = a[W-2:0] >= b[W-2:0] ? b : a;
    de = l[W-2:F] - t[W-2:F];
    sh = int'(de) > F + 4 ? F + 5 : int'(de);
    ml = {1'b1, l[F-1:0], 3'b0};
    ms = {1'b1, t[F-1:0], 3'b0};
    msa = ms >> sh;
    // bits shifted out of the smaller operand collapse into the sticky position
    msa[0] = msa[0] | ((msa << sh) != ms);
    e = {2'b0, l[W-2:F]};
    if (l[W-1] == t[W-1]) begin
      sum = {1'b0, ml} + {1'b0, msa};
      return sum[F+4] ? round_pack(l[W-1], e + (E + 2)'(1), {sum[F+4:2], |sum[1:0]}, rm) : round_pack(l[W-1], e, sum[F+3:0], rm);
    end
    d4 = ml - msa;
    if (d4 == '0) return {5'b0, rm == RDN, {(W-1){1'b0}}};
    n = lzc(d4);
    return round_pack(l[W-1], e - (E + 2)'(n), d4 << n, rm);
  endfunction
  always_comb begin
    w_fused = r_cmd >= FMADD;
    w_a = (w_fused ? r_prod : r_s1) ^ {r_cmd == FNMADD || r_cmd == FNMSUB, {(W-1){1'b0}}};
    w_b = (w_fused ? r_s3 : r_s2) ^ {r_cmd == FSUB || r_cmd == FMSUB || r_cmd == FNMADD, {(W-1){1'b0}}};
    w_mul = fp_mul(r_s1, r_s2, r_rm);
    w_add = fp_add(w_a, w_b, r_rm);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = i_kill ? IDLE :
             r_state == IDLE ? (i_req_valid ? (i_command <= FSUB ? ADD : MUL) : IDLE) :
             r_state == MUL ? (r_cmd == FMUL ? DONE : ADD) :
             r_state == ADD ? DONE :
             i_resp_ready ? IDLE : DONE;
  always_comb begin
    o_req_ready = r_state == IDLE;
    o_resp_valid = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cmd <= '0;
      r_rm <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_prod <= '0;
      r_result <= '0;
      r_flags <= '0;
    end else if (i_kill) begin
      r_flags <= '0;
    end else if (r_state == IDLE && i_req_valid) begin
      r_cmd <= i_command;
      r_rm <= i_rounding_mode;
      r_s1 <= i_fp_src1;
      r_s2 <= i_fp_src2;
      r_s3 <= i_fp_src3;
      r_flags <= '0;
    end else if (r_state == MUL) begin
      r_prod <= w_mul[W-1:0];
      r_flags <= r_flags | w_mul[W+4:W];
      if (r_cmd == FMUL) r_result <= w_mul[W-1:0];
    end else if (r_state == ADD) begin
      r_result <= w_add[W-1:0];
      r_flags <= r_flags | w_add[W+4:W];
    end
  assign o_fp_result = r_result;
  assign o_flags = r_flags;
endmodule

// File: tb/tb_fp_mul_add_unit.sv
// tb_fp_mul_add_unit: directed self-checking bench for fp_mul_add_unit (binary32)
module tb_fp_mul_add_unit;
  localparam logic [2:0] FADD = 3'd0, FSUB = 3'd1, FMUL = 3'd2, FMADD = 3'd3, FMSUB = 3'd4, FNMADD = 3'd5, FNMSUB = 3'd6;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3;
  localparam logic [4:0] NV = 5'h10, OF = 5'h04, UF = 5'h02, NX = 5'h01;
  logic clk = 1'b0, rst = 1'b1, kill = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic req_ready, resp_valid;
  logic [2:0] cmd = '0, rm = '0;
  logic [31:0] s1 = '0, s2 = '0, s3 = '0, res;
  logic [4:0] flags;
  logic seen;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  fp_mul_add_unit dut (
    .clk(clk), .rst(rst), .i_kill(kill), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_command(cmd), .i_rounding_mode(rm), .i_fp_src1(s1), .i_fp_src2(s2), .i_fp_src3(s3),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_fp_result(res), .o_flags(flags)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic op(input string tag, input logic [2:0] c, input logic [2:0] r, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] d, input logic [31:0] exp_res, input logic [4:0] exp_fl, input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    cmd = c; rm = r; s1 = a; s2 = b; s3 = d; req_valid = 1'b1; resp_ready = hold == 0;
    @(posedge clk); #1;
    req_valid = 1'b0; cmd = FADD; rm = RUP; s1 = $urandom; s2 = $urandom; s3 = $urandom;
    n = 1;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, res, exp_res);
    check({tag, " flags"}, 32'(flags), 32'(exp_fl));
    if (hold > 0) begin
      req_valid = 1'b1;
      cmd = FMUL;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
        check({tag, " hold ready"}, 32'(req_ready), 32'd0);
        check({tag, " hold result"}, res, exp_res);
        check({tag, " hold flags"}, 32'(flags), 32'(exp_fl));
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " handoff valid"}, 32'(resp_valid), 32'd0);
    check({tag, " handoff ready"}, 32'(req_ready), 32'd1);
  endtask
  task automatic quiet(input string tag, input int cycles);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen = seen | resp_valid;
    end
    check({tag, " no response"}, 32'(seen), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset valid", 32'(resp_valid), 32'd0);
    check("reset result", res, 32'h0);
    check("reset flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op("fmul 1.5*2", FMUL, RNE, 32'h3FC00000, 32'h40000000, 32'h0, 32'h40400000, 5'h0, 2, 0);
    op("fmadd", FMADD, RNE, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40800000, 5'h0, 3, 0);
    op("fnmsub", FNMSUB, RNE, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'hC0000000, 5'h0, 3, 0);
    op("fmsub", FMSUB, RNE, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40000000, 5'h0, 3, 0);
    op("fnmadd", FNMADD, RNE, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'hC0800000, 5'h0, 3, 0);
    op("ovf rne", FMUL, RNE, 32'h7F000000, 32'h7F000000, 32'h0, 32'h7F800000, OF | NX, 2, 0);
    op("ovf rtz", FMUL, RTZ, 32'h7F000000, 32'h7F000000, 32'h0, 32'h7F7FFFFF, OF | NX, 2, 0);
    op("ovf neg rup", FMUL, RUP, 32'hFF000000, 32'h7F000000, 32'h0, 32'hFF7FFFFF, OF | NX, 2, 0);
    op("ovf neg rdn", FMUL, RDN, 32'hFF000000, 32'h7F000000, 32'h0, 32'hFF800000, OF | NX, 2, 0);
    op("inf-inf", FSUB, RNE, 32'h7F800000, 32'h7F800000, 32'h0, 32'h7FC00000, NV, 2, 0);
    op("0*-inf", FMUL, RNE, 32'h00000000, 32'hFF800000, 32'h0, 32'h7FC00000, NV, 2, 0);
    op("inf*-2", FMUL, RNE, 32'h7F800000, 32'hC0000000, 32'h0, 32'hFF800000, 5'h0, 2, 0);
    op("tie rne", FADD, RNE, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, NX, 2, 0);
    op("tie rup", FADD, RUP, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800001, NX, 2, 0);
    op("underflow", FMUL, RNE, 32'h00800000, 32'h00800000, 32'h0, 32'h00000000, UF | NX, 2, 0);
    op("qnan in", FADD, RNE, 32'h7FC00001, 32'h3F800000, 32'h0, 32'h7FC00000, 5'h0, 2, 0);
    op("snan in", FMUL, RNE, 32'h7F800001, 32'h3F800000, 32'h0, 32'h7FC00000, NV, 2, 0);
    op("-0+-0", FADD, RNE, 32'h80000000, 32'h80000000, 32'h0, 32'h80000000, 5'h0, 2, 0);
    op("1-1 rne", FSUB, RNE, 32'h3F800000, 32'h3F800000, 32'h0, 32'h00000000, 5'h0, 2, 0);
    op("1-1 rdn", FSUB, RDN, 32'h3F800000, 32'h3F800000, 32'h0, 32'h80000000, 5'h0, 2, 0);
    op("backpressure", FMADD, RNE, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40800000, 5'h0, 3, 4);
    op("after handoff", FMUL, RNE, 32'h3FC00000, 32'h40000000, 32'h0, 32'h40400000, 5'h0, 2, 0);
    @(negedge clk);
    cmd = FMUL; s1 = 32'h3F800000; s2 = 32'h3F800000; req_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    check("kill idle ready", 32'(req_ready), 32'd1);
    quiet("kill idle", 4);
    @(negedge clk);
    cmd = FMADD; rm = RNE; s1 = 32'h7F000000; s2 = 32'h7F000000; s3 = 32'h3F800000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("kill mul busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill mul ready", 32'(req_ready), 32'd1);
    check("kill mul valid", 32'(resp_valid), 32'd0);
    quiet("kill mul", 4);
    op("fadd after kill", FADD, RNE, 32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'h0, 2, 0);
    @(negedge clk);
    cmd = FMADD; s1 = 32'h3FC00000; s2 = 32'h40000000; s3 = 32'h3F800000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst ready", 32'(req_ready), 32'd1);
    check("async rst valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet("async rst", 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
